// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end.
// Owns the fetch PC and issues word-aligned reads to a memory with one cycle of
// read latency. It buffers {pc, instruction} pairs in a DEPTH-entry queue for
// decode. A branch or jump redirect flushes the queue and drops the stale
// in-flight response.
//
// Decode handshake: inst_valid means the head entry (inst_pc/instruction) is
// meaningful. The head is consumed on a rising clock edge where
// inst_valid && inst_ready is true and no redirect is requested. inst_valid
// does not depend on inst_ready. The payload is stable while inst_valid is
// high and the head is not consumed. In a redirect cycle the head is flushed
// rather than delivered.
module fetch_queue_unit #(
  parameter int               XLEN         = 32,
  parameter int               DEPTH        = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_tgt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]     OCC_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
  localparam logic [XLEN-1:0] TGT_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

  // Fetch state
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_req_pc;

  // Queue state
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Combinational control
  logic            w_redirect;
  logic [XLEN-1:0] w_raw_tgt;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_occupancy;
  logic            w_issue;
  logic [XLEN-1:0] w_addr;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;

  // Redirect selection, credit-based issue decision and queue push/pop strobes.
  // Occupancy counts queued entries plus the one possibly in flight. A pop in
  // the same cycle does not free a credit early.
  always_comb begin
    w_redirect  = jump | branch_taken;
    w_raw_tgt   = jump ? jump_tgt : branch_tgt;
    w_target    = w_raw_tgt & TGT_MASK;
    w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_issue     = !reset && (w_redirect || (w_occupancy < OCC_LIMIT));
    w_addr      = w_redirect ? w_target : r_fetch_pc;
    w_valid     = !reset && (r_count != '0);
    w_push      = !reset && r_inflight && !w_redirect;
    w_pop       = w_valid && inst_ready && !w_redirect;
  end

  assign imem_req    = w_issue;
  assign imem_addr   = w_addr;
  assign inst_valid  = w_valid;
  assign instruction = reset ? '0 : r_inst_mem[r_rd_ptr];
  assign inst_pc     = reset ? '0 : r_pc_mem[r_rd_ptr];

  // Fetch PC, in-flight flag and the address of the outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_VECTOR;
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
    end else if (w_issue) begin
      r_fetch_pc <= w_addr + XLEN'(4);
      r_inflight <= 1'b1;
      r_req_pc   <= w_addr;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Queue payload storage; written only by an accepted response
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_req_pc;
      r_inst_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  // Queue pointers and count; a redirect empties the queue outright
  always_ff @(posedge clk) begin
    if (reset || w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The credit scheme must make a push into a full queue impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == CNT_FULL)));

endmodule
